seq_mul_add: RTL and testbench

//  Iterative shift-add multiply-accumulate computing result = quotient*divisor + remainder.

---
 rtl/seq_mul_add.sv | 130 +++++++++++++
 tb/tb_seq_mul_add.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul_add.sv
// Iterative shift-add multiply-accumulate: result = quotient*divisor + remainder.
// Rebuilds a dividend from divider outputs; unsigned or two's-complement operands.
module seq_mul_add #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 mode,
   input  logic [WIDTH-1:0]     quotient,
   input  logic [WIDTH-1:0]     divisor,
   input  logic [WIDTH-1:0]     remainder,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic                 fits
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_FIX,
      S_DONE
   } state_t;

   state_t               r_state;
   logic [WIDTH-1:0]     r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [WIDTH-1:0]     r_rem;
   logic [2*WIDTH-1:0]   r_acc;
   logic [CW-1:0]        r_cnt;
   logic                 r_mode;
   logic                 r_neg;
   logic                 r_out_valid;
   logic [2*WIDTH-1:0]   r_result;
   logic                 r_fits;

   logic                 w_q_neg;
   logic                 w_d_neg;
   logic [WIDTH-1:0]     w_q_mag;
   logic [WIDTH-1:0]     w_d_mag;
   logic [WIDTH:0]       w_sum;
   logic [2*WIDTH-1:0]   w_prod;
   logic [2*WIDTH-1:0]   w_rem_ext;
   logic [2*WIDTH-1:0]   w_res;
   logic                 w_fits;

   // Magnitudes are taken on the raw inputs so the multiply loop is always unsigned;
   // the most negative value maps to 2^(WIDTH-1), which still fits WIDTH unsigned bits.
   assign w_q_neg = mode & quotient[WIDTH-1];
   assign w_d_neg = mode & divisor[WIDTH-1];
   assign w_q_mag = w_q_neg ? (~quotient + 1'b1) : quotient;
   assign w_d_mag = w_d_neg ? (~divisor + 1'b1) : divisor;

   // One extra bit keeps the carry of the upper-half add before the right shift.
   assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);

   assign w_prod    = r_neg ? (~r_acc + 1'b1) : r_acc;
   assign w_rem_ext = {{WIDTH{r_mode & r_rem[WIDTH-1]}}, r_rem};
   assign w_res     = w_prod + w_rem_ext;
   assign w_fits    = r_mode ? ((&w_res[2*WIDTH-1:WIDTH-1]) | ~(|w_res[2*WIDTH-1:WIDTH-1]))
                             : ~(|w_res[2*WIDTH-1:WIDTH]);

   // NOTE: every register below is updated with <= so all next-state values are
   // computed from the same pre-edge snapshot, regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_rem       <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_mode      <= 1'b0;
         r_neg       <= 1'b0;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_fits      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_mcand  <= w_q_mag;
                  r_mplier <= w_d_mag;
                  r_rem    <= remainder;
                  r_mode   <= mode;
                  r_neg    <= w_q_neg ^ w_d_neg;
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_state  <= S_MUL;
               end
            end
            S_MUL: begin
               r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == LAST_BIT) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_result <= w_res;
               r_fits   <= w_fits;
               r_state  <= S_DONE;
            end
            S_DONE: begin
               // out_valid is registered, so it is guaranteed a full cycle before
               // the consumer's out_ready can retire the result.
               if (r_out_valid && out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end else begin
                  r_out_valid <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign fits      = r_fits;

endmodule

// File: tb/tb_seq_mul_add.sv
// Self-checking bench for seq_mul_add: directed literal cases plus random
// operands scored against a wide-integer arithmetic model.
module tb_seq_mul_add;

   localparam int W = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic            mode;
   logic [W-1:0]    quotient;
   logic [W-1:0]    divisor;
   logic [W-1:0]    remainder;
   logic            out_valid;
   logic            out_ready;
   logic [2*W-1:0]  result;
   logic            fits;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [64:0] exp_q[$];
   logic [64:0] mon_e;

   seq_mul_add #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .quotient  (quotient),
      .divisor   (divisor),
      .remainder (remainder),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .fits      (fits)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
   endtask

   // Plain integer arithmetic on 128-bit signed values; returns {fits, result}.
   function automatic logic [64:0] model(input logic m, input logic [31:0] q,
                                         input logic [31:0] d, input logic [31:0] r);
      logic signed [127:0] qv, dv, rv, full;
      logic [63:0] res;
      logic f;
      qv = m ? {{96{q[31]}}, q} : {96'd0, q};
      dv = m ? {{96{d[31]}}, d} : {96'd0, d};
      rv = m ? {{96{r[31]}}, r} : {96'd0, r};
      full = qv * dv + rv;
      res = full[63:0];
      if (!m) f = (res < 64'h1_0000_0000);
      else    f = ($signed(res) >= -64'sd2147483648) && ($signed(res) <= 64'sd2147483647);
      return {f, res};
   endfunction

   // Scoreboard: push on accept, compare whenever out_valid, pop on handshake.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
               mon_e = exp_q[0];
               check("sb_result", result, mon_e[63:0]);
               check("sb_fits", 64'(fits), 64'(mon_e[64]));
               check("sb_busy_in_ready", 64'(in_ready), 64'd0);
               if (out_ready) void'(exp_q.pop_front());
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(mode, quotient, divisor, remainder));
      end
   end

   task automatic send(input logic m, input logic [31:0] q, input logic [31:0] d,
                       input logic [31:0] r);
      bit acc;
      int n;
      n = 0;
      acc = 1'b0;
      mode = m; quotient = q; divisor = d; remainder = r; in_valid = 1'b1;
      do begin
         @(negedge clk); acc = in_ready;
         @(posedge clk); #1; n++;
      end while (!acc && n < 100);
      if (!acc) check("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      mode = 1'($urandom); quotient = $urandom; divisor = $urandom; remainder = $urandom;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
      if (!out_valid) check("valid_timeout", 64'd0, 64'd1);
   endtask

   task automatic recv(input int hold, output logic [63:0] res, output logic f);
      res = result;
      f = fits;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; mode = 1'($urandom);
         quotient = $urandom; divisor = $urandom; remainder = $urandom;
         @(posedge clk); #1;
         check("hold_out_valid", 64'(out_valid), 64'd1);
         check("hold_result", result, res);
         check("hold_fits", 64'(fits), 64'(f));
         check("hold_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid = 1'b0;
      check("drop_out_valid", 64'(out_valid), 64'd0);
      check("result_held_after_hs", result, res);
      check("idle_in_ready", 64'(in_ready), 64'd1);
   endtask

   task automatic run_op(input logic m, input logic [31:0] q, input logic [31:0] d,
                         input logic [31:0] r, input int hold, input bit rdy_early,
                         output logic [63:0] res, output logic f, output int lat);
      send(m, q, d, r);
      if (rdy_early) out_ready = 1'b1;
      wait_valid(lat);
      recv(rdy_early ? 0 : hold, res, f);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   typedef struct {
      logic        m;
      logic [31:0] q, d, r;
      logic [63:0] res;
      logic        f;
   } vec_t;

   vec_t vecs[6] = '{
      '{1'b0, 32'd16,          32'd3,           32'd2,           64'd50,                  1'b1},
      '{1'b1, 32'hFFFF_FFF0,   32'd3,           32'hFFFF_FFFE,   64'hFFFF_FFFF_FFFF_FFCE, 1'b1},
      '{1'b1, 32'hFFFF_FFF0,   32'hFFFF_FFFD,   32'd2,           64'd50,                  1'b1},
      '{1'b0, 32'd123,         32'd0,           32'd50,          64'd50,                  1'b1},
      '{1'b1, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           64'h0000_0000_8000_0000, 1'b0},
      '{1'b0, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   32'hFFFF_FFFF,   64'hFFFF_FFFF_0000_0000, 1'b0}
   };

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] res;
      logic        f;
      logic [64:0] me;
      int          lat;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0;
      quotient = '0; divisor = '0; remainder = '0;
      #12;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_result", result, 64'd0);
      check("rst_fits", 64'(fits), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         me = model(vecs[i].m, vecs[i].q, vecs[i].d, vecs[i].r);
         check($sformatf("model_res_%0d", i), me[63:0], vecs[i].res);
         check($sformatf("model_fits_%0d", i), 64'(me[64]), 64'(vecs[i].f));
         run_op(vecs[i].m, vecs[i].q, vecs[i].d, vecs[i].r, (i == 0) ? 5 : 0,
                (i == 3), res, f, lat);
         check($sformatf("dir_res_%0d", i), res, vecs[i].res);
         check($sformatf("dir_fits_%0d", i), 64'(f), 64'(vecs[i].f));
         check($sformatf("latency_%0d", i), 64'(lat), 64'(W + 2));
      end

      // Reset in the middle of MUL aborts the operation.
      send(1'b0, 32'd1234, 32'd5678, 32'd9);
      repeat (10) @(posedge clk);
      #2; rst_n = 1'b0;
      #1;
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("aborted_no_result", 64'(out_valid), 64'd0);
      run_op(1'b0, 32'd7, 32'd6, 32'd0, 1, 1'b0, res, f, lat);
      check("post_rst_res", res, 64'd42);
      check("post_rst_fits", 64'(f), 64'd1);

      for (int i = 0; i < 40; i++) begin
         run_op(1'($urandom), pick(), pick(), pick(), $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0), res, f, lat);
         check("rand_latency", 64'(lat), 64'(W + 2));
      end

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
